// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and types for the scoreboarded register file
package reg_file_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
    localparam int ZERO_REG     = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - single WIDTH-bit storage register with write enable
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - NUM_REGS x WIDTH register file with pending bits; WRITE_BYPASS_EN enables write forwarding
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int   WIDTH    = WIDTH_DEF,
    parameter int   NUM_REGS = NUM_REGS_DEF,
    localparam int  ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WriteReg,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic [WIDTH-1:0]  DstData,
    input  logic              ResvEn,
    input  logic [ADDR_W-1:0] ResvReg,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [WIDTH-1:0]  SrcData1,
    output logic [WIDTH-1:0]  SrcData2,
    output logic              SrcPend1,
    output logic              SrcPend2
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            pend;
    logic                           wr_ok;
    logic                           resv_ok;

    assign wr_ok   = WriteReg && (DstReg != ZERO_IDX);
    assign resv_ok = ResvEn && (ResvReg != ZERO_IDX);

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .we  (wr_ok && (DstReg == ADDR_W'(i))),
            .d   (DstData),
            .q   (regs[i])
        );
    end

    // Reserve is applied after the write clear so a same-index reservation leaves the bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (wr_ok) begin
                pend[DstReg] <= 1'b0;
            end
            if (resv_ok) begin
                pend[ResvReg] <= 1'b1;
            end
        end
    end

    always_comb begin
        SrcData1 = regs[SrcReg1];
        SrcData2 = regs[SrcReg2];
        SrcPend1 = pend[SrcReg1];
        SrcPend2 = pend[SrcReg2];
`ifdef WRITE_BYPASS_EN
        if (wr_ok && (DstReg == SrcReg1)) begin
            SrcData1 = DstData;
            SrcPend1 = ResvEn && (ResvReg == DstReg);
        end
        if (wr_ok && (DstReg == SrcReg2)) begin
            SrcData2 = DstData;
            SrcPend2 = ResvEn && (ResvReg == DstReg);
        end
`endif
    end

endmodule
